sprite_mem_arbiter: RTL and testbench

//  Shares the single asynchronous-read memory port between CPU load/store traffic and sprite-load (LS) bursts.
//  A sprite LS needs BURST_LEN back-to-back beats with the memory address presented every cycle.

---
 rtl/sprite_arb_pkg.sv | 32 +++
 rtl/arb_burst_counter.sv | 33 +++
 rtl/sprite_mem_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types for the sprite/CPU memory arbiter: FSM states, port owner
// encoding, default geometry and a saturating-increment helper.
package sprite_arb_pkg;

    localparam int ARB_ADDR_W    = 16;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_BURST_LEN = 64;
    localparam int ARB_CPU_MAX   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPR_BURST = 2'd1,
        CPU_RUN   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_SPR = 1'b1
    } owner_t;

    // Increment a 16-bit statistic, holding at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Loadable up-counter with a terminal-count flag. The count holds at MAX_VAL
// so it never wraps; tc is high while the count equals TC_VAL.
module arb_burst_counter #(
    parameter int W       = 7,
    parameter int MAX_VAL = 64,
    parameter int TC_VAL  = 63
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Count register: load wins over increment; increment stops at MAX_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (inc && (cnt_r != W'(MAX_VAL))) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == W'(TC_VAL));

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Arbiter sharing one asynchronous-read memory port between CPU load/store
// traffic and sprite-load bursts. A sprite grant locks the port for up to
// BURST_LEN beats; the CPU gets at most CPU_MAX consecutive beats while a
// sprite request is pending; otherwise ownership alternates round-robin.
// Grants are combinational so the grant cycle is the access cycle.
// Optional build macro: SPRITE_MEM_ARB_STATS_EN adds stat_cpu_wait and
// stat_bursts statistic outputs without changing arbitration.
module sprite_mem_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int CPU_MAX   = ARB_CPU_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_gnt,
    output logic [DATA_W-1:0] spr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef SPRITE_MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_wait,
    output logic [15:0]       stat_bursts
`endif
);

    localparam int   BEAT_W   = $clog2(BURST_LEN) + 1;
    localparam int   RUN_W    = $clog2(CPU_MAX) + 1;
    // A single-beat burst completes in the cycle it is granted.
    localparam logic ONE_BEAT = (BURST_LEN == 1);

    arb_state_t state_r, next_state_s;
    owner_t     last_owner_r, owner_val_s;
    logic       owner_set_s;
    logic       cpu_gnt_s, spr_gnt_s;
    logic       beat_load_s, beat_inc_s, beat_tc_s;
    logic       run_load_s, run_inc_s, run_tc_s;

    // Beat counter: 1 after the first sprite beat, tc flags the last beat.
    arb_burst_counter #(
        .W       (BEAT_W),
        .MAX_VAL (BURST_LEN),
        .TC_VAL  (BURST_LEN - 1)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load_s),
        .load_val (BEAT_W'(1)),
        .inc      (beat_inc_s),
        .tc       (beat_tc_s)
    );

    // Run counter: consecutive CPU beats, tc flags the CPU_MAX limit.
    arb_burst_counter #(
        .W       (RUN_W),
        .MAX_VAL (CPU_MAX),
        .TC_VAL  (CPU_MAX)
    ) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (run_load_s),
        .load_val (RUN_W'(1)),
        .inc      (run_inc_s),
        .tc       (run_tc_s)
    );

    // State and last-owner registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= OWN_CPU;
        end else begin
            state_r <= next_state_s;
            if (owner_set_s) begin
                last_owner_r <= owner_val_s;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Next-state and grant decode from registered state and live requests.
    always_comb begin
        next_state_s = state_r;
        cpu_gnt_s    = 1'b0;
        spr_gnt_s    = 1'b0;
        beat_load_s  = 1'b0;
        beat_inc_s   = 1'b0;
        run_load_s   = 1'b0;
        run_inc_s    = 1'b0;
        owner_set_s  = 1'b0;
        owner_val_s  = last_owner_r;
        if (!rst_n) begin
            // Nothing is granted while reset is held.
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (spr_req && (!cpu_req || (last_owner_r == OWN_CPU))) begin
                        spr_gnt_s   = 1'b1;
                        beat_load_s = 1'b1;
                        if (ONE_BEAT) begin
                            owner_set_s  = 1'b1;
                            owner_val_s  = OWN_SPR;
                            next_state_s = IDLE;
                        end else begin
                            next_state_s = SPR_BURST;
                        end
                    end else if (cpu_req) begin
                        cpu_gnt_s    = 1'b1;
                        run_load_s   = 1'b1;
                        next_state_s = CPU_RUN;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SPR_BURST: begin
                    if (spr_req) begin
                        spr_gnt_s  = 1'b1;
                        beat_inc_s = 1'b1;
                        if (beat_tc_s) begin
                            owner_set_s  = 1'b1;
                            owner_val_s  = OWN_SPR;
                            next_state_s = IDLE;
                        end else begin
                            next_state_s = SPR_BURST;
                        end
                    end else begin
                        // Early release: the sprite side gave up the port.
                        owner_set_s  = 1'b1;
                        owner_val_s  = OWN_SPR;
                        next_state_s = IDLE;
                    end
                end
                CPU_RUN: begin
                    if (spr_req && (run_tc_s || !cpu_req)) begin
                        // Hand the port to the sprite side with no idle bubble.
                        spr_gnt_s   = 1'b1;
                        beat_load_s = 1'b1;
                        owner_set_s = 1'b1;
                        if (ONE_BEAT) begin
                            owner_val_s  = OWN_SPR;
                            next_state_s = IDLE;
                        end else begin
                            owner_val_s  = OWN_CPU;
                            next_state_s = SPR_BURST;
                        end
                    end else if (cpu_req) begin
                        cpu_gnt_s    = 1'b1;
                        run_inc_s    = 1'b1;
                        next_state_s = CPU_RUN;
                    end else begin
                        owner_set_s  = 1'b1;
                        owner_val_s  = OWN_CPU;
                        next_state_s = IDLE;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Memory port mux: the granted side drives the port, otherwise it is quiet.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
        if (spr_gnt_s) begin
            mem_addr = spr_addr;
            mem_re   = 1'b1;
        end else if (cpu_gnt_s) begin
            mem_addr  = cpu_addr;
            mem_re    = !cpu_we;
            mem_we    = cpu_we;
            mem_wdata = cpu_we ? cpu_wdata : {DATA_W{1'b0}};
        end else begin
            mem_addr = {ADDR_W{1'b0}};
        end
    end

    assign cpu_gnt   = cpu_gnt_s;
    assign spr_gnt   = spr_gnt_s;
    assign cpu_rdata = mem_rdata;
    assign spr_rdata = mem_rdata;

`ifdef SPRITE_MEM_ARB_STATS_EN
    logic [15:0] stat_cpu_wait_r;
    logic [15:0] stat_bursts_r;
    logic        burst_done_s;

    // A full-length burst completes on the grant of its final beat.
    assign burst_done_s = spr_gnt_s & ((state_r == SPR_BURST) ? beat_tc_s : ONE_BEAT);

    // Statistics: CPU stall cycles saturate, completed bursts wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_wait_r <= 16'd0;
            stat_bursts_r   <= 16'd0;
        end else begin
            if (cpu_req && !cpu_gnt_s) begin
                stat_cpu_wait_r <= sat_inc16(stat_cpu_wait_r);
            end else begin
                stat_cpu_wait_r <= stat_cpu_wait_r;
            end
            if (burst_done_s) begin
                stat_bursts_r <= stat_bursts_r + 16'd1;
            end else begin
                stat_bursts_r <= stat_bursts_r;
            end
        end
    end

    assign stat_cpu_wait = stat_cpu_wait_r;
    assign stat_bursts   = stat_bursts_r;
`endif

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed self-checking bench for sprite_mem_arbiter with an asynchronous-
// read memory model. Honours SPRITE_MEM_ARB_STATS_EN for the statistic ports.
module tb_sprite_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic [31:0] cpu_rdata;
    logic        spr_req;
    logic [15:0] spr_addr;
    logic        spr_gnt;
    logic [31:0] spr_rdata;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef SPRITE_MEM_ARB_STATS_EN
    logic [15:0] stat_cpu_wait;
    logic [15:0] stat_bursts;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_array [0:65535];

    sprite_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .spr_req   (spr_req),
        .spr_addr  (spr_addr),
        .spr_gnt   (spr_gnt),
        .spr_rdata (spr_rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef SPRITE_MEM_ARB_STATS_EN
        ,
        .stat_cpu_wait (stat_cpu_wait),
        .stat_bursts   (stat_bursts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background contents of the memory model.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {16'hA5C3, a};
    endfunction

    // Asynchronous-read, synchronous-write memory model.
    assign mem_rdata = mem_array[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem_array[mem_addr] <= mem_wdata;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop both requests and let the arbiter settle in IDLE.
    task automatic go_idle();
        cpu_req = 1'b0;
        spr_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; spr_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 16'h0040; spr_addr = 16'h1000; cpu_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b0000 || mem_addr !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_outputs: got gnt/re/we=%b addr=%h, expected 0000 addr=0000",
                         {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr);
            end
            step();
        end
        cpu_req = 1'b0; spr_req = 1'b0; cpu_we = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sprite_burst();
        logic [15:0] ea;
        for (int i = 0; i < 64; i++) begin
            ea = 16'h1000 + 16'(i);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
            spr_req = 1'b1; spr_addr = ea;
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b0110 || mem_addr !== ea
                || spr_rdata !== pat(ea)) begin
                n_err++;
                $display("FAIL burst_beat %0d: got gnt/re/we=%b addr=%h data=%h, expected 0110 addr=%h data=%h",
                         i + 1, {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr, spr_rdata, ea, pat(ea));
            end
            step();
        end
        spr_req = 1'b0;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b1010 || mem_addr !== 16'h0040
            || cpu_rdata !== pat(16'h0040)) begin
            n_err++;
            $display("FAIL burst_cpu_after: got gnt/re/we=%b addr=%h data=%h, expected 1010 addr=0040 data=%h",
                     {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr, cpu_rdata, pat(16'h0040));
        end
        step();
    endtask

`ifdef SPRITE_MEM_ARB_STATS_EN
    task automatic test_stats();
        n_vec++;
        if (stat_cpu_wait !== 16'd64 || stat_bursts !== 16'd1) begin
            n_err++;
            $display("FAIL stats: got wait=%0d bursts=%0d, expected wait=64 bursts=1",
                     stat_cpu_wait, stat_bursts);
        end
    endtask
`endif

    task automatic test_cpu_rw();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'hDEADBEEF;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b1001 || mem_addr !== 16'h0020
            || mem_wdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL cpu_write: got gnt/re/we=%b addr=%h wdata=%h, expected 1001 addr=0020 wdata=deadbeef",
                     {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr, mem_wdata);
        end
        step();
        cpu_we = 1'b0;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b1010 || mem_addr !== 16'h0020
            || cpu_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL cpu_read: got gnt/re/we=%b addr=%h rdata=%h, expected 1010 addr=0020 rdata=deadbeef",
                     {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr, cpu_rdata);
        end
        step();
        go_idle();
    endtask

    task automatic test_cpu_limit();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; spr_req = 1'b0;
        spr_addr = 16'h2000;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL limit_beat1: got gnt=%b expected 10", {cpu_gnt, spr_gnt});
        end
        step();
        spr_req = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt} !== 2'b10) begin
                n_err++;
                $display("FAIL limit_cpu_beat %0d: got gnt=%b expected 10", b, {cpu_gnt, spr_gnt});
            end
            step();
        end
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b01 || mem_addr !== 16'h2000) begin
            n_err++;
            $display("FAIL limit_handoff: got gnt=%b addr=%h expected 01 addr=2000",
                     {cpu_gnt, spr_gnt}, mem_addr);
        end
        step();
        spr_addr = 16'h2001;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b01) begin
            n_err++;
            $display("FAIL limit_in_burst: got gnt=%b expected 01", {cpu_gnt, spr_gnt});
        end
        step();
        go_idle();
    endtask

    task automatic test_handoff_no_cpu();
        cpu_req = 1'b1; spr_req = 1'b0;
        step();
        cpu_req = 1'b0; spr_req = 1'b1; spr_addr = 16'h2800;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b01 || mem_addr !== 16'h2800) begin
            n_err++;
            $display("FAIL handoff_cpu_idle: got gnt=%b addr=%h expected 01 addr=2800",
                     {cpu_gnt, spr_gnt}, mem_addr);
        end
        step();
        go_idle();
    endtask

    task automatic test_early_release();
        // One CPU access first so last_owner starts as CPU.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; spr_req = 1'b0;
        step();
        cpu_req = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            spr_req = 1'b1; spr_addr = 16'h3000 + 16'(i);
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt} !== 2'b01) begin
                n_err++;
                $display("FAIL early_beat %0d: got gnt=%b expected 01", i + 1, {cpu_gnt, spr_gnt});
            end
            step();
        end
        spr_req = 1'b0; cpu_req = 1'b1;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b0000 || mem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL early_release: got gnt/re/we=%b addr=%h expected 0000 addr=0000",
                     {cpu_gnt, spr_gnt, mem_re, mem_we}, mem_addr);
        end
        step();
        spr_req = 1'b1;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL early_next_owner: got gnt=%b expected 10", {cpu_gnt, spr_gnt});
        end
        step();
        go_idle();
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1'b0; spr_req = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            spr_addr = 16'h4000 + 16'(i);
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt} !== 2'b01) begin
                n_err++;
                $display("FAIL midrst_beat %0d: got gnt=%b expected 01", i, {cpu_gnt, spr_gnt});
            end
            step();
        end
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt, mem_re, mem_we} !== 4'b0000) begin
                n_err++;
                $display("FAIL midrst_held: got gnt/re/we=%b expected 0000",
                         {cpu_gnt, spr_gnt, mem_re, mem_we});
            end
            step();
        end
        rst_n = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        // A fresh burst must run the full 64 beats before the CPU gets in.
        for (int i = 1; i <= 64; i++) begin
            spr_addr = 16'h5000 + 16'(i);
            #2;
            n_vec++;
            if ({cpu_gnt, spr_gnt} !== 2'b01) begin
                n_err++;
                $display("FAIL midrst_fresh_beat %0d: got gnt=%b expected 01", i, {cpu_gnt, spr_gnt});
            end
            step();
        end
        spr_req = 1'b0;
        #2;
        n_vec++;
        if ({cpu_gnt, spr_gnt} !== 2'b10 || mem_addr !== 16'h0300) begin
            n_err++;
            $display("FAIL midrst_cpu_after: got gnt=%b addr=%h expected 10 addr=0300",
                     {cpu_gnt, spr_gnt}, mem_addr);
        end
        step();
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_array[i] = pat(16'(i));
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0;
        cpu_wdata = 32'h0; spr_req = 1'b0; spr_addr = 16'h0;
        step();
        test_reset();
        test_sprite_burst();
`ifdef SPRITE_MEM_ARB_STATS_EN
        test_stats();
`endif
        go_idle();
        test_cpu_rw();
        test_cpu_limit();
        test_handoff_no_cpu();
        test_early_release();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
